// File: rtl/csmulti_rr_scheduler.sv
// Round-robin scheduler sharing one carry-save array multiplier among NUM_REQ
// requesters; operands are held for SETTLE_CYCLES before the product is captured.

module csmulti_fullbasecell #(
    parameter int bitsize = 8
) (
    input  logic [bitsize-1:0]   factor0,
    input  logic [bitsize-1:0]   factor1,
    output logic [2*bitsize-1:0] product
);
    localparam int PW = 2 * bitsize;

    logic [PW-1:0] sum_v;
    logic [PW-1:0] carry_v;
    logic [PW-1:0] pp_v;
    logic [PW-1:0] tmp_v;

    // Each row folds one partial product into the sum/carry pair; one final add resolves it.
    always_comb begin
        sum_v   = '0;
        carry_v = '0;
        pp_v    = '0;
        tmp_v   = '0;
        for (int i = 0; i < bitsize; i++) begin
            // NOTE: blocking assignments here model a chain of combinational rows;
            // each row must see the previous row's result within the same evaluation.
            pp_v    = factor1[i] ? (PW'(factor0) << i) : '0;
            tmp_v   = sum_v ^ carry_v ^ pp_v;
            carry_v = ((sum_v & carry_v) | (sum_v & pp_v) | (carry_v & pp_v)) << 1;
            sum_v   = tmp_v;
        end
        product = sum_v + carry_v;
    end
endmodule

module csmulti_rr_scheduler #(
    parameter int BITSIZE       = 8,
    parameter int NUM_REQ       = 4,
    parameter int SETTLE_CYCLES = 2,
    parameter int IDW           = $clog2(NUM_REQ)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*BITSIZE-1:0] req_factor0,
    input  logic [NUM_REQ*BITSIZE-1:0] req_factor1,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [IDW-1:0]             rsp_id,
    output logic [2*BITSIZE-1:0]       rsp_product,
    output logic                       busy
);
    localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, CALC, RESP} state_e;

    state_e               state_q, state_d;
    logic [IDW-1:0]       ptr_q, ptr_d;
    logic [IDW-1:0]       id_q, id_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [BITSIZE-1:0]   a_q, a_d;
    logic [BITSIZE-1:0]   b_q, b_d;
    logic [2*BITSIZE-1:0] prod_q, prod_d;
    logic [2*BITSIZE-1:0] mul_product;

    logic                 grant_valid;
    logic [IDW-1:0]       grant_idx;
    logic [IDW-1:0]       cand;
    int                   cand_int;

    csmulti_fullbasecell #(.bitsize(BITSIZE)) u_mul (
        .factor0 (a_q),
        .factor1 (b_q),
        .product (mul_product)
    );

    // First valid requester at or cyclically after ptr_q.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        cand_int    = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand_int = (int'(ptr_q) + k) % NUM_REQ;
            cand     = IDW'(cand_int);
            if (!grant_valid && req_valid[cand]) begin
                grant_valid = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    always_comb begin
        // NOTE: every variable gets its hold value first, so no branch can leave
        // one unassigned and infer a latch.
        state_d = state_q;
        ptr_d   = ptr_q;
        id_d    = id_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        prod_d  = prod_q;
        case (state_q)
            IDLE: begin
                if (grant_valid) begin
                    a_d     = req_factor0[int'(grant_idx)*BITSIZE +: BITSIZE];
                    b_d     = req_factor1[int'(grant_idx)*BITSIZE +: BITSIZE];
                    id_d    = grant_idx;
                    cnt_d   = CW'(SETTLE_CYCLES - 1);
                    state_d = CALC;
                end
            end
            CALC: begin
                if (cnt_q == '0) begin
                    prod_d  = mul_product;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    ptr_d   = (id_q == IDW'(NUM_REQ - 1)) ? '0 : id_q + 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: datapath registers are reset too, since a discarded operation
            // must leave no operand or product visible at the outputs.
            state_q <= IDLE;
            ptr_q   <= '0;
            id_q    <= '0;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            prod_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            prod_q  <= prod_d;
        end
    end

    assign req_ready   = (rst_n && state_q == IDLE && grant_valid) ? (NUM_REQ'(1) << grant_idx) : '0;
    assign rsp_valid   = (state_q == RESP);
    assign rsp_id      = id_q;
    assign rsp_product = prod_q;
    assign busy        = (state_q != IDLE);
endmodule

// File: tb/tb_csmulti_rr_scheduler.sv
// Scoreboard bench for csmulti_rr_scheduler: stimulus pushes expected responses,
// independent monitors pop/compare responses and log grants.

module tb_csmulti_rr_scheduler;
    localparam int BITSIZE = 8;
    localparam int NUM_REQ = 4;
    localparam int IDW     = 2;

    typedef struct {
        int id;
        int prod;
    } rsp_t;

    logic                       clk = 1'b0;
    logic                       rst_n;
    logic [NUM_REQ-1:0]         req_valid;
    logic [NUM_REQ*BITSIZE-1:0] req_factor0;
    logic [NUM_REQ*BITSIZE-1:0] req_factor1;
    logic [NUM_REQ-1:0]         req_ready;
    logic                       rsp_valid;
    logic                       rsp_ready;
    logic [IDW-1:0]             rsp_id;
    logic [2*BITSIZE-1:0]       rsp_product;
    logic                       busy;

    int   checks = 0;
    int   errors = 0;
    rsp_t sb_q[$];
    int   grant_q[$];

    csmulti_rr_scheduler #(.BITSIZE(BITSIZE), .NUM_REQ(NUM_REQ), .SETTLE_CYCLES(2)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_factor0 (req_factor0),
        .req_factor1 (req_factor1),
        .req_ready   (req_ready),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_id      (rsp_id),
        .rsp_product (rsp_product),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, actual, expected);
        end
    endtask

    // Response monitor: every handshake must match the oldest expected entry.
    always begin
        @(negedge clk);
        #2;
        if (rst_n && rsp_valid && rsp_ready) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rsp: got id=%0d product=%0d, required none", rsp_id, rsp_product);
            end else begin
                rsp_t e;
                e = sb_q.pop_front();
                check("rsp_id", 32'(rsp_id), e.id);
                check("rsp_product", 32'(rsp_product), e.prod);
            end
        end
    end

    // Grant monitor: logs each granted index once per IDLE grant cycle.
    always begin
        @(negedge clk);
        #2;
        if (rst_n && req_ready != '0) begin
            check("req_ready_onehot", $countones(req_ready), 1);
            check("req_ready_within_valid", 32'(req_ready & ~req_valid), 0);
            for (int i = 0; i < NUM_REQ; i++)
                if (req_ready[i]) grant_q.push_back(i);
        end
    end

    initial begin
        repeat (20000) @(posedge clk);
        $display("FAIL watchdog: simulation exceeded cycle budget");
        $fatal(1, "watchdog");
    end

    task automatic issue(input int id, input int f0, input int f1, input bit expect_rsp);
        rsp_t e;
        req_factor0[id*BITSIZE +: BITSIZE] = 8'(f0);
        req_factor1[id*BITSIZE +: BITSIZE] = 8'(f1);
        req_valid[id] = 1'b1;
        if (expect_rsp) begin
            e.id   = id;
            e.prod = f0 * f1;
            sb_q.push_back(e);
        end
    endtask

    // Called at a falling edge; returns at falling edge +3 in the grant cycle.
    task automatic expect_grant(input int id, input string name);
        bit seen = 1'b0;
        #3;
        for (int n = 0; n < 40 && !seen; n++) begin
            if (grant_q.size() > 0) begin
                check(name, grant_q.pop_front(), id);
                seen = 1'b1;
            end else begin
                @(negedge clk);
                #3;
            end
        end
        if (!seen) check({name, "_timeout"}, 0, 1);
    endtask

    task automatic release_req(input int id);
        @(posedge clk);
        @(negedge clk);
        req_valid[id] = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        bit done = 1'b0;
        for (int n = 0; n < 100 && !done; n++) begin
            @(negedge clk);
            #3;
            if (sb_q.size() == 0 && !busy) done = 1'b1;
        end
        check({name, "_drained"}, sb_q.size(), 0);
    endtask

    initial begin
        rst_n       = 1'b0;
        req_valid   = '1;
        req_factor0 = '0;
        req_factor1 = '0;
        rsp_ready   = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("rst_req_ready", 32'(req_ready), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_rsp_valid", 32'(rsp_valid), 0);
        check("rst_rsp_id", 32'(rsp_id), 0);
        check("rst_rsp_product", 32'(rsp_product), 0);
        req_valid = '0;
        rst_n     = 1'b1;

        // Round-robin fairness from ptr=0
        @(negedge clk);
        issue(0, 2, 3, 1'b1);
        issue(1, 4, 5, 1'b1);
        issue(2, 6, 7, 1'b1);
        issue(3, 8, 9, 1'b1);
        sb_q.push_back('{id: 0, prod: 6});
        expect_grant(0, "rr_grant0");
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            expect_grant(k % NUM_REQ, $sformatf("rr_grant%0d", k));
        end
        @(posedge clk);
        @(negedge clk);
        req_valid = '0;
        wait_drain("rr");

        // Single request with latency checks
        @(negedge clk);
        issue(1, 13, 11, 1'b1);
        expect_grant(1, "single_grant");
        @(posedge clk);
        @(negedge clk);
        #1;
        check("single_req_ready_calc", 32'(req_ready), 0);
        check("single_busy_calc", 32'(busy), 1);
        check("single_rsp_valid_e1", 32'(rsp_valid), 0);
        req_valid[1] = 1'b0;
        @(negedge clk);
        #1;
        check("single_rsp_valid_e2", 32'(rsp_valid), 0);
        @(negedge clk);
        #1;
        check("single_rsp_valid_rise", 32'(rsp_valid), 1);
        @(negedge clk);
        #1;
        check("single_idle_after", 32'(busy), 0);
        check("single_extra_grants", grant_q.size(), 0);
        wait_drain("single");

        // Extremes
        @(negedge clk);
        issue(0, 255, 255, 1'b1);
        expect_grant(0, "ext_grant_max");
        release_req(0);
        issue(0, 0, 200, 1'b1);
        expect_grant(0, "ext_grant_zero");
        release_req(0);
        wait_drain("extremes");

        // Backpressure with req 2 held valid
        @(negedge clk);
        rsp_ready = 1'b0;
        issue(2, 5, 6, 1'b1);
        sb_q.push_back('{id: 2, prod: 30});
        expect_grant(2, "bp_grant_first");
        begin
            bit up = 1'b0;
            for (int n = 0; n < 20 && !up; n++) begin
                @(negedge clk);
                #1;
                up = rsp_valid;
            end
            check("bp_rsp_valid_rise", 32'(up), 1);
        end
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            #1;
            check("bp_hold_valid", 32'(rsp_valid), 1);
            check("bp_hold_product", 32'(rsp_product), 30);
            check("bp_hold_id", 32'(rsp_id), 2);
            check("bp_hold_req_ready", 32'(req_ready), 0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        #3;
        check("bp_regrant_count", grant_q.size(), 1);
        if (grant_q.size() > 0) check("bp_regrant_id", grant_q.pop_front(), 2);
        @(posedge clk);
        @(negedge clk);
        req_valid = '0;
        wait_drain("backpressure");

        // Reset mid-CALC; 100*3 must never be reported
        @(negedge clk);
        issue(1, 100, 3, 1'b0);
        expect_grant(1, "rstcalc_grant");
        @(posedge clk);
        @(negedge clk);
        req_valid = '0;
        rst_n     = 1'b0;
        #1;
        check("rstcalc_busy_before", 32'(busy), 1);
        @(negedge clk);
        #1;
        check("rstcalc_busy", 32'(busy), 0);
        check("rstcalc_rsp_valid", 32'(rsp_valid), 0);
        check("rstcalc_rsp_product", 32'(rsp_product), 0);
        check("rstcalc_rsp_id", 32'(rsp_id), 0);
        check("rstcalc_ptr", 32'(dut.ptr_q), 0);
        check("rstcalc_a_q", 32'(dut.a_q), 0);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        issue(2, 7, 9, 1'b1);
        expect_grant(2, "rstcalc_followup_grant");
        release_req(2);
        wait_drain("rstcalc");

        // Late pointer update: after req 3, ptr wraps to 0
        @(negedge clk);
        issue(3, 5, 5, 1'b1);
        expect_grant(3, "late_grant3_first");
        release_req(3);
        wait_drain("late_first");
        @(negedge clk);
        issue(0, 3, 4, 1'b1);
        issue(3, 10, 10, 1'b1);
        expect_grant(0, "late_grant0");
        release_req(0);
        expect_grant(3, "late_grant3");
        release_req(3);
        wait_drain("late");

        check("final_grants_left", grant_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
